// File: rtl/pixel_autorange.sv
// Per-frame min/max tracker and 8-bit normaliser. Each pixel is scaled with the
// range of the previous frame; a serial divider turns that range into a scale.
module pixel_autorange #(
  parameter  int MAX_ADDR = 63,
  parameter  int IN_W     = 16,
  parameter  int FRAC_W   = 16,
  localparam int ADDRW    = $clog2(MAX_ADDR + 1),
  localparam int QW       = FRAC_W + 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_valid,
  input  logic [ADDRW-1:0] i_wr_addr,
  input  logic [IN_W-1:0]  i_wr_data,
  output logic             o_wr_valid,
  output logic [ADDRW-1:0] o_wr_addr,
  output logic [7:0]       o_wr_data,
  output logic             o_frame_done,
  output logic             o_busy,
  output logic [IN_W-1:0]  o_min,
  output logic [IN_W-1:0]  o_max
);

  localparam int CW = $clog2(QW);
  localparam int PW = IN_W + QW;
  localparam logic [QW-1:0] DIVIDEND  = QW'(255) << FRAC_W;
  localparam logic [QW-1:0] DEF_SCALE = QW'(1) << (QW - IN_W);

  typedef enum logic [1:0] {IDLE, DIV, COMMIT} state_t;

  state_t            state_q, state_d;
  logic              accept, frame_end;
  logic [IN_W-1:0]   acc_min_q, acc_max_q, fmin, fmax;
  logic [IN_W-1:0]   min_lat_q, max_lat_q, span_q;
  logic [IN_W-1:0]   act_min_q;
  logic [QW-1:0]     act_scale_q;
  logic [CW-1:0]     cnt_q;
  logic [IN_W-1:0]   rem_q, rem_d, diff;
  logic [QW-1:0]     quo_q;
  logic [IN_W:0]     trial;
  logic              ge;

  assign accept    = i_wr_valid && ({1'b0, i_wr_addr} <= (ADDRW+1)'(MAX_ADDR));
  assign frame_end = accept && (i_wr_addr == ADDRW'(MAX_ADDR));

  // Range including the current sample, so the frame-end pixel counts.
  assign fmin = (i_wr_data < acc_min_q) ? i_wr_data : acc_min_q;
  assign fmax = (i_wr_data > acc_max_q) ? i_wr_data : acc_max_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_min_q <= '1;
      acc_max_q <= '0;
    end else if (frame_end) begin
      acc_min_q <= '1;
      acc_max_q <= '0;
    end else if (accept) begin
      acc_min_q <= fmin;
      acc_max_q <= fmax;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_end) state_d = DIV;
      DIV:     if (frame_end) state_d = DIV;
               else if (cnt_q == CW'(QW - 1)) state_d = COMMIT;
      COMMIT:  state_d = frame_end ? DIV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign o_busy = (state_q != IDLE);

  // Restoring divider: quo_q starts as the dividend and fills with quotient bits.
  assign trial = {rem_q, quo_q[QW-1]};
  assign ge    = (trial >= {1'b0, span_q});
  assign diff  = trial[IN_W-1:0] - span_q;
  assign rem_d = ge ? diff : trial[IN_W-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      span_q      <= IN_W'(1);
      min_lat_q   <= '0;
      max_lat_q   <= '0;
      act_min_q   <= '0;
      act_scale_q <= DEF_SCALE;
    end else begin
      if (frame_end) begin
        min_lat_q <= fmin;
        max_lat_q <= fmax;
        span_q    <= (fmax == fmin) ? IN_W'(1) : fmax - fmin;
        cnt_q     <= '0;
        rem_q     <= '0;
        quo_q     <= DIVIDEND;
      end else if (state_q == DIV) begin
        rem_q <= rem_d;
        quo_q <= {quo_q[QW-2:0], ge};
        cnt_q <= cnt_q + CW'(1);
      end
      // A frame end landing on COMMIT makes this result stale; drop it.
      if (state_q == COMMIT && !frame_end) begin
        act_scale_q <= quo_q;
        act_min_q   <= min_lat_q;
      end
    end
  end

  assign o_min = min_lat_q;
  assign o_max = max_lat_q;

  logic [1:0]       vld_pipe_q, fd_pipe_q;
  logic [ADDRW-1:0] addr1_q, addr2_q;
  logic [IN_W-1:0]  d_s1, d1_q;
  logic [QW-1:0]    scale1_q;
  logic [PW-1:0]    prod_sh;
  logic [7:0]       pix_d, pix_q;

  assign d_s1    = (i_wr_data < act_min_q) ? '0 : i_wr_data - act_min_q;
  assign prod_sh = (PW'(d1_q) * PW'(scale1_q)) >> FRAC_W;
  assign pix_d   = (|prod_sh[PW-1:8]) ? 8'hFF : prod_sh[7:0];

  // Min and scale are captured together so one pixel never mixes two frames.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_pipe_q <= '0;
      fd_pipe_q  <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      d1_q       <= '0;
      scale1_q   <= '0;
      pix_q      <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], accept};
      fd_pipe_q  <= {fd_pipe_q[0], frame_end};
      addr1_q    <= i_wr_addr;
      addr2_q    <= addr1_q;
      d1_q       <= d_s1;
      scale1_q   <= act_scale_q;
      pix_q      <= pix_d;
    end
  end

  assign o_wr_valid   = vld_pipe_q[1];
  assign o_frame_done = fd_pipe_q[1];
  assign o_wr_addr    = addr2_q;
  assign o_wr_data    = pix_q;

endmodule
